// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side. A granted requester
// keeps the port until its last beat or MAX_BURST beats; beats are blocked while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATASIZE  = 8,
    parameter int MAX_BURST = 8,
    localparam int OWN_W    = $clog2(NUM_REQ)
) (
    input  logic                        i_wclk,
    input  logic                        i_wrst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ-1:0]          i_last,
    input  logic [NUM_REQ*DATASIZE-1:0] i_wdata,
    input  logic                        i_wfull_flag,
    output logic [NUM_REQ-1:0]          o_gnt,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic                        o_w_en,
    output logic [DATASIZE-1:0]         o_wdata,
    output logic [OWN_W-1:0]            o_owner,
    output logic                        o_busy
);

    // Handshake: a requester beat is valid when i_req[k] is high; it is taken (ready)
    // only in a cycle where o_ack[k] is high. i_req/i_last/i_wdata of a requester must
    // stay stable until that beat is acked.

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]         state;
    logic [NUM_REQ-1:0] gnt;
    logic [OWN_W-1:0]   owner;
    logic [OWN_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;

    logic               pick_valid;
    logic [OWN_W-1:0]   pick_idx;
    logic               accept;
    logic               burst_end;

    // Search starts just after the last owner, so it becomes lowest priority.
    always_comb begin
        int idx_int;
        logic [OWN_W-1:0] cand;
        idx_int    = 0;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_int = (int'(rr_ptr) + i) % NUM_REQ;
            cand    = OWN_W'(idx_int);
            if (!pick_valid && i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign accept    = (state == ST_BURST) && i_req[owner] && !i_wfull_flag;
    assign burst_end = accept && (i_last[owner] || (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge i_wclk) begin
        if (i_wrst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= OWN_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state    <= ST_BURST;
                        gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner    <= pick_idx;
                        rr_ptr   <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (burst_end) begin
                        state    <= ST_IDLE;
                        gnt      <= '0;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign o_gnt   = gnt;
    assign o_owner = owner;
    assign o_busy  = (state == ST_BURST);
    assign o_w_en  = accept;
    assign o_ack   = gnt & i_req & {NUM_REQ{!i_wfull_flag}};
    assign o_wdata = i_wdata[owner*DATASIZE +: DATASIZE];

    a_no_write_when_full : assert property (@(posedge i_wclk) disable iff (i_wrst)
        !(o_w_en && i_wfull_flag));
    a_gnt_onehot0 : assert property (@(posedge i_wclk) disable iff (i_wrst)
        $onehot0(o_gnt));
    a_write_only_busy : assert property (@(posedge i_wclk) disable iff (i_wrst)
        !(o_w_en && !o_busy));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for grant rotation, hand sequences
// for packets, burst limit, full stalls and mid-burst reset, with a write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  logic              i_wclk;
  logic              i_wrst;
  logic [3:0]        i_req;
  logic [3:0]        i_last;
  logic [4*DW-1:0]   i_wdata;
  logic              i_wfull_flag;
  logic [3:0]        o_gnt;
  logic [3:0]        o_ack;
  logic              o_w_en;
  logic [DW-1:0]     o_wdata;
  logic [1:0]        o_owner;
  logic              o_busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic sb_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATASIZE(DW), .MAX_BURST(8)) dut (
    .i_wclk       (i_wclk),
    .i_wrst       (i_wrst),
    .i_req        (i_req),
    .i_last       (i_last),
    .i_wdata      (i_wdata),
    .i_wfull_flag (i_wfull_flag),
    .o_gnt        (o_gnt),
    .o_ack        (o_ack),
    .o_w_en       (o_w_en),
    .o_wdata      (o_wdata),
    .o_owner      (o_owner),
    .o_busy       (o_busy)
  );

  // clock / reset
  initial begin
    i_wclk = 1'b0;
    forever #5 i_wclk = ~i_wclk;
  end

  initial begin
    i_wrst       = 1'b1;
    i_req        = '0;
    i_last       = '0;
    i_wdata      = '0;
    i_wfull_flag = 1'b0;
  end

  // driver tasks
  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] last,
                       input logic full);
    @(posedge i_wclk);
    #1;
    i_wrst       = rst;
    i_req        = req;
    i_last       = last;
    i_wfull_flag = full;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    i_wdata[k*DW +: DW] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input string tag, input logic [3:0] gnt, input logic wen,
                        input logic busy);
    @(negedge i_wclk);
    chk({tag, ".gnt"},  32'(o_gnt),  32'(gnt));
    chk({tag, ".wen"},  32'(o_w_en), 32'(wen));
    chk({tag, ".busy"}, 32'(o_busy), 32'(busy));
    chk({tag, ".ack"},  32'(o_ack),  32'(wen ? gnt : 4'b0000));
  endtask

  // scoreboard
  always @(negedge i_wclk) begin
    if (sb_en && o_w_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: got unexpected write %0h expected none at %0t", o_wdata, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (o_wdata !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %0h expected %0h at %0t", o_wdata, e, $time);
        end
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] gnt;
    logic       wen;
    int         src;
    logic       busy;
  } vec_t;

  vec_t vt[12];

  initial begin
    // grant rotation table: all requesting, single-beat packets
    vt[0]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, -1, 1'b0};
    vt[1]  = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1,  0, 1'b1};
    vt[2]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, -1, 1'b0};
    vt[3]  = '{4'hF, 4'hF, 1'b0, 4'b0010, 1'b1,  1, 1'b1};
    vt[4]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, -1, 1'b0};
    vt[5]  = '{4'hF, 4'hF, 1'b0, 4'b0100, 1'b1,  2, 1'b1};
    vt[6]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, -1, 1'b0};
    vt[7]  = '{4'hF, 4'hF, 1'b0, 4'b1000, 1'b1,  3, 1'b1};
    vt[8]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, -1, 1'b0};
    vt[9]  = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1,  0, 1'b1};
    vt[10] = '{4'h0, 4'h0, 1'b0, 4'b0000, 1'b0, -1, 1'b0};
    vt[11] = '{4'h0, 4'h0, 1'b0, 4'b0000, 1'b0, -1, 1'b0};

    // reset state
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    sample("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset.owner", 32'(o_owner), 32'd0);

    // table: requester k presents 0x10*(k+1)+i in vector i
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, vt[i].req, vt[i].last, vt[i].full);
      for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 * (k + 1) + i));
      sample($sformatf("vec%0d", i), vt[i].gnt, vt[i].wen, vt[i].busy);
      if (vt[i].busy) chk($sformatf("vec%0d.owner", i), 32'(o_owner), 32'(vt[i].src));
      if (vt[i].wen)
        chk($sformatf("vec%0d.wdata", i), 32'(o_wdata), 32'(8'h10 * (vt[i].src + 1) + i));
    end

    sb_en = 1'b1;

    // 3-beat packet from req0 while req1 waits
    drive(1'b0, 4'b0001, 4'b0000, 1'b0); set_data(0, 8'hD0);
    sample("pkt.idle", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0011, 4'b0000, 1'b0); set_data(1, 8'hE1); exp_q.push_back(8'hD0);
    sample("pkt.b0", 4'b0001, 1'b1, 1'b1);
    drive(1'b0, 4'b0011, 4'b0000, 1'b0); set_data(0, 8'hD1); exp_q.push_back(8'hD1);
    sample("pkt.b1", 4'b0001, 1'b1, 1'b1);
    drive(1'b0, 4'b0011, 4'b0001, 1'b0); set_data(0, 8'hD2); exp_q.push_back(8'hD2);
    sample("pkt.b2", 4'b0001, 1'b1, 1'b1);
    drive(1'b0, 4'b0010, 4'b0010, 1'b0);
    sample("pkt.gap", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 4'b0010, 1'b0); exp_q.push_back(8'hE1);
    sample("pkt.req1", 4'b0010, 1'b1, 1'b1);
    chk("pkt.req1.owner", 32'(o_owner), 32'd1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    sample("pkt.end", 4'b0000, 1'b0, 1'b0);

    // MAX_BURST forced release: req2 streams without last, req3 waiting
    drive(1'b0, 4'b1100, 4'b0000, 1'b0); set_data(3, 8'h3C);
    sample("burst.idle", 4'b0000, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      drive(1'b0, 4'b1100, 4'b0000, 1'b0);
      set_data(2, 8'(8'h80 + b)); exp_q.push_back(8'(8'h80 + b));
      sample($sformatf("burst.b%0d", b), 4'b0100, 1'b1, 1'b1);
    end
    drive(1'b0, 4'b1100, 4'b0000, 1'b0);
    sample("burst.gap", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b1100, 4'b1000, 1'b0); exp_q.push_back(8'h3C);
    sample("burst.req3", 4'b1000, 1'b1, 1'b1);
    chk("burst.req3.owner", 32'(o_owner), 32'd3);
    // req2 alone is granted again after its own forced release
    drive(1'b0, 4'b0100, 4'b0000, 1'b0);
    sample("alone.idle", 4'b0000, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      drive(1'b0, 4'b0100, 4'b0000, 1'b0);
      set_data(2, 8'(8'h90 + b)); exp_q.push_back(8'(8'h90 + b));
      sample($sformatf("alone.b%0d", b), 4'b0100, 1'b1, 1'b1);
    end
    drive(1'b0, 4'b0100, 4'b0000, 1'b0);
    sample("alone.gap", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0100, 4'b0100, 1'b0); set_data(2, 8'hA5); exp_q.push_back(8'hA5);
    sample("alone.regrant", 4'b0100, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    sample("alone.end", 4'b0000, 1'b0, 1'b0);

    // full stall after beat 2 of 4, then owner drops req with a stray last
    drive(1'b0, 4'b0010, 4'b0000, 1'b0);
    sample("full.idle", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 4'b0000, 1'b0); set_data(1, 8'h51); exp_q.push_back(8'h51);
    sample("full.b1", 4'b0010, 1'b1, 1'b1);
    drive(1'b0, 4'b0010, 4'b0000, 1'b0); set_data(1, 8'h52); exp_q.push_back(8'h52);
    sample("full.b2", 4'b0010, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b0010, 4'b0010, 1'b1); set_data(1, 8'h53);
      sample($sformatf("full.stall%0d", c), 4'b0010, 1'b0, 1'b1);
    end
    drive(1'b0, 4'b0000, 4'b0010, 1'b0);
    sample("full.drop", 4'b0010, 1'b0, 1'b1);
    drive(1'b0, 4'b0010, 4'b0000, 1'b0); exp_q.push_back(8'h53);
    sample("full.b3", 4'b0010, 1'b1, 1'b1);
    drive(1'b0, 4'b0010, 4'b0010, 1'b0); set_data(1, 8'h54); exp_q.push_back(8'h54);
    sample("full.b4", 4'b0010, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    sample("full.end", 4'b0000, 1'b0, 1'b0);

    // reset during beat 2 of a req1 burst
    drive(1'b0, 4'b0010, 4'b0000, 1'b0);
    sample("rst.idle", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 4'b0000, 1'b0); set_data(1, 8'h61); exp_q.push_back(8'h61);
    sample("rst.b1", 4'b0010, 1'b1, 1'b1);
    drive(1'b1, 4'b0010, 4'b0000, 1'b0); set_data(1, 8'h62); sb_en = 1'b0;
    drive(1'b0, 4'hF, 4'hF, 1'b0); set_data(0, 8'h70); sb_en = 1'b1;
    sample("rst.after", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'hF, 4'hF, 1'b0); exp_q.push_back(8'h70);
    sample("rst.regrant", 4'b0001, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    sample("rst.end", 4'b0000, 1'b0, 1'b0);

    chk("sb.leftover", 32'(exp_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
